block_framer: RTL and testbench

BLOCK_FRAMER -- requirements
Module: block_framer

---
 rtl/block_framer.sv | 150 +++++++++++++++
 tb/tb_block_framer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_framer.sv
// UART byte framer for a block cipher: assembles key/plaintext frames, streams ciphertext back.
// Optional inter-byte abort timer is enabled with macro FRAMER_TIMEOUT_EN.
module block_framer #(
    parameter int         BLOCK_BYTES    = 16,
    parameter logic [7:0] KEY_CMD        = 8'h4B,
    parameter logic [7:0] PT_CMD         = 8'h50,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_done,
    output logic [8*BLOCK_BYTES-1:0] pt_out,
    output logic                     aes_start,
    input  logic                     aes_ready,
    input  logic [8*BLOCK_BYTES-1:0] ct_in,
    output logic [8*BLOCK_BYTES-1:0] key_out,
    output logic                     key_write_en,
    output logic                     busy,
    output logic                     err
);
    localparam int W  = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {IDLE, RX_KEY, RX_PT, AES_WAIT, TX_SEND, TX_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  asm_reg, asm_nxt, tx_sr;
    logic          err_nxt, rx_take, tx_adv, timeout_hit, frame_done;

`ifdef FRAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // Counts consecutive byte-less clocks while a frame is open; zero elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if ((state == RX_KEY || state == RX_PT) && !rx_valid)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end

    assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        rx_take   = 1'b0;
        tx_adv    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == KEY_CMD)     state_nxt = RX_KEY;
                    else if (rx_data == PT_CMD) state_nxt = RX_PT;
                    else                        err_nxt   = 1'b1;
                end
            end
            RX_KEY, RX_PT: begin
                if (rx_valid) begin
                    rx_take = 1'b1;
                    if (cnt == LAST) begin
                        if (state == RX_KEY) state_nxt = IDLE;
                        else                 state_nxt = AES_WAIT;
                    end
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            AES_WAIT: begin
                err_nxt = rx_valid;
                if (aes_ready) state_nxt = TX_SEND;
            end
            TX_SEND: begin
                err_nxt   = rx_valid;
                state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                // A stray rx byte and tx_done in the same cycle are both honoured.
                err_nxt = rx_valid;
                if (tx_done) begin
                    tx_adv = 1'b1;
                    if (cnt == LAST) state_nxt = IDLE;
                    else             state_nxt = TX_SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign asm_nxt    = (asm_reg << 8) | {{(W-8){1'b0}}, rx_data};
    assign frame_done = rx_take && (cnt == LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            asm_reg      <= '0;
            tx_sr        <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            pt_out       <= '0;
            aes_start    <= 1'b0;
            key_out      <= '0;
            key_write_en <= 1'b0;
            err          <= 1'b0;
        end else begin
            err          <= err_nxt;
            key_write_en <= frame_done && (state == RX_KEY);
            aes_start    <= frame_done && (state == RX_PT);
            tx_start     <= (state == TX_SEND);
            if (state == IDLE) cnt <= '0;
            if (rx_take) begin
                asm_reg <= asm_nxt;
                cnt     <= cnt + 1'b1;
            end
            // Outputs only move on a complete frame, so aborted frames leave them intact.
            if (frame_done) begin
                if (state == RX_KEY) key_out <= asm_nxt;
                else                 pt_out  <= asm_nxt;
            end
            if (state == AES_WAIT && aes_ready) begin
                tx_sr <= ct_in;
                cnt   <= '0;
            end
            if (state == TX_SEND) tx_data <= tx_sr[W-1 -: 8];
            if (tx_adv) begin
                tx_sr <= tx_sr << 8;
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_block_framer.sv
// Directed bench for block_framer: frame-level queue model checked every cycle, plus literal expectations.
module tb_block_framer;
    localparam int BB = 16;
    localparam int W  = 8 * BB;

    logic         clk = 1'b0, reset = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0, tx_done = 1'b0, aes_ready = 1'b0;
    logic [W-1:0] ct_in = '0;
    wire  [7:0]   tx_data;
    wire          tx_start, aes_start, key_write_en, busy, err;
    wire  [W-1:0] pt_out, key_out;

    always #5 clk = ~clk;

    block_framer #(.BLOCK_BYTES(BB), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .pt_out(pt_out), .aes_start(aes_start), .aes_ready(aes_ready), .ct_in(ct_in),
        .key_out(key_out), .key_write_en(key_write_en), .busy(busy), .err(err)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef enum int {M_IDLE, M_KEY, M_PT, M_WAIT, M_SEND, M_TXW} mode_t;
    mode_t        mode = M_IDLE;
    logic [7:0]   rxq[$];
    logic [7:0]   txq[$];
    int           idle_n = 0;
    logic [W-1:0] m_key = '0, m_pt = '0;
    logic         m_kwe = 0, m_aes = 0, m_err = 0, m_txs = 0;
    logic [7:0]   m_txd = 8'h00;

    function automatic logic [W-1:0] pack_q(input logic [7:0] q[$]);
        logic [W-1:0] v = '0;
        foreach (q[i]) v = (v << 8) | W'(q[i]);
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mode = M_IDLE; m_key = '0; m_pt = '0; idle_n = 0;
            m_kwe = 0; m_aes = 0; m_err = 0; m_txs = 0; m_txd = 8'h00;
            rxq.delete(); txq.delete();
        end else begin
            m_kwe = 0; m_aes = 0; m_err = 0; m_txs = 0;
            case (mode)
                M_IDLE: if (rx_valid) begin
                    rxq.delete(); idle_n = 0;
                    if (rx_data == 8'h4B)      mode = M_KEY;
                    else if (rx_data == 8'h50) mode = M_PT;
                    else                       m_err = 1;
                end
                M_KEY, M_PT: if (rx_valid) begin
                    idle_n = 0;
                    rxq.push_back(rx_data);
                    if (rxq.size() == BB) begin
                        if (mode == M_KEY) begin m_key = pack_q(rxq); m_kwe = 1; mode = M_IDLE; end
                        else begin m_pt = pack_q(rxq); m_aes = 1; mode = M_WAIT; end
                    end
                end else begin
                    idle_n++;
`ifdef FRAMER_TIMEOUT_EN
                    if (idle_n == 100) begin m_err = 1; mode = M_IDLE; end
`endif
                end
                M_WAIT: begin
                    if (rx_valid) m_err = 1;
                    if (aes_ready) begin
                        txq.delete();
                        for (int i = 0; i < BB; i++) txq.push_back(ct_in[W-1-8*i -: 8]);
                        mode = M_SEND;
                    end
                end
                M_SEND: begin
                    if (rx_valid) m_err = 1;
                    m_txs = 1; m_txd = txq[0]; mode = M_TXW;
                end
                M_TXW: begin
                    if (rx_valid) m_err = 1;
                    if (tx_done) begin
                        void'(txq.pop_front());
                        if (txq.size() == 0) mode = M_IDLE;
                        else                 mode = M_SEND;
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    logic [7:0] tx_log[$];
    int kwe_seen = 0, aes_seen = 0, err_seen = 0, txs_seen = 0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, mode != M_IDLE);
            chk("err", err, m_err);
            chk("key_write_en", key_write_en, m_kwe);
            chk("aes_start", aes_start, m_aes);
            chk("tx_start", tx_start, m_txs);
            chk("key_out", key_out, m_key);
            chk("pt_out", pt_out, m_pt);
            if (m_txs) chk("tx_data", tx_data, m_txd);
            if (tx_start) begin tx_log.push_back(tx_data); txs_seen++; end
            if (key_write_en) kwe_seen++;
            if (aes_start) aes_seen++;
            if (err) err_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] dead[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    int e0, k0, a0, t0;
    logic got;

    initial begin
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_tx", {tx_data, tx_start, aes_start, key_write_en, err}, 0);
        chk("rst_key", key_out, 0);
        chk("rst_pt", pt_out, 0);
        reset = 1'b0;

        send(8'h4B);
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) send(dead[j]);
        idle(3);
        chk("key_lit", key_out, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
        chk("kwe_once", kwe_seen, 1);
        chk("m_key_lit", m_key, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);

        send(8'h50);
        for (int r = 0; r < 8; r++) begin send(8'hFF); send(8'h00); end
        idle(3);
        chk("pt_lit", pt_out, 128'hff00ff00ff00ff00ff00ff00ff00ff00);
        chk("aes_once", aes_seen, 1);
        chk("busy_wait", busy, 1);

        e0 = err_seen;
        @(posedge clk); #1 ct_in = 128'h00112233445566778899aabbccddeeff; aes_ready = 1'b1;
        @(posedge clk); #1 aes_ready = 1'b0;
        for (int k = 0; k < BB; k++) begin
            got = 1'b0;
            for (int n = 0; n < 30 && !got; n++) begin
                @(negedge clk);
                if (tx_start) got = 1'b1;
            end
            chk("tx_start_wait", got, 1);
            @(posedge clk); #1 rx_data = 8'h12; rx_valid = (k == 3);
            @(posedge clk); #1 rx_valid = (k == 6); tx_done = 1'b1;
            @(posedge clk); #1 rx_valid = 1'b0; tx_done = 1'b0;
        end
        idle(3);
        chk("tx_count", tx_log.size(), BB);
        for (int k = 0; k < BB && k < tx_log.size(); k++) chk("tx_byte", tx_log[k], 8'(k * 8'h11));
        chk("busy_done", busy, 0);
        chk("err_in_tx", err_seen - e0, 2);

        e0 = err_seen;
        send(8'h33);
        idle(2);
        chk("err_idle", err_seen - e0, 1);
        chk("busy_idle", busy, 0);

        send(8'h50);
        for (int j = 0; j < 5; j++) send(8'(8'hA0 + j));
`ifdef FRAMER_TIMEOUT_EN
        e0 = err_seen;
        idle(105);
        chk("to_err", err_seen - e0, 1);
        chk("to_busy", busy, 0);
        chk("to_pt", pt_out, 128'hff00ff00ff00ff00ff00ff00ff00ff00);
        send(8'h4B);
        for (int j = 0; j < 3; j++) send(8'h77);
`else
        idle(150);
        chk("no_to_busy", busy, 1);
        chk("no_to_pt", pt_out, 128'hff00ff00ff00ff00ff00ff00ff00ff00);
`endif

        k0 = kwe_seen; a0 = aes_seen; e0 = err_seen; t0 = txs_seen;
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx", {tx_data, tx_start, aes_start, key_write_en, err}, 0);
        chk("mid_rst_key", key_out, 0);
        chk("mid_rst_pt", pt_out, 0);
        @(negedge clk); reset = 1'b0;
        idle(20);
        chk("no_strobes", (kwe_seen - k0) + (aes_seen - a0) + (err_seen - e0) + (txs_seen - t0), 0);
        chk("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
